// File: rtl/issue_ctrl_pkg.sv
// Shared opcode constants, scheduler state encoding and bus width for the
// IF/ID launch scheduler.
package issue_ctrl_pkg;

    localparam int INST_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/issue_ctrl_inst_dec_lite.sv
// Lightweight RV32I decode: register fields plus the class bits that the
// launch scheduler needs for pair and load-use hazard checks.
module inst_dec_lite
    import issue_ctrl_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output logic [4:0]        rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              wr_rd,
    output logic              is_mem,
    output logic              is_ld,
    output logic              is_ctl
);

    logic [6:0] opc;
    logic       unused_bits;

    assign opc         = inst[6:0];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    // x0 sources are masked here so no downstream comparison can match on them
    assign use_rs1 = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL)
                     && (rs1 != 5'd0);
    assign use_rs2 = ((opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP))
                     && (rs2 != 5'd0);
    assign wr_rd   = (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd != 5'd0);
    assign is_ld   = (opc == OPC_LOAD);
    assign is_mem  = (opc == OPC_LOAD) || (opc == OPC_STORE);
    assign is_ctl  = (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);

endmodule

// File: rtl/issue_ctrl.sv
// Launch scheduler for the dual-slot instruction buffer: picks 0/1/2 head
// entries per cycle, tracks load-use and post-branch flush, counts stalls.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sendout_flag1,
    input  logic              sendout_flag2,
    input  logic [INST_W-1:0] out1_inst,
    input  logic [INST_W-1:0] out2_inst,
    input  logic              ex_ready,
    input  logic              branch_flag,
    output logic              launch_flag1,
    output logic              launch_flag2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  dual_cnt
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [4:0] rd1, rs1_1, rs2_1, rd2, rs1_2, rs2_2;
    logic       u1_rs1, u1_rs2, wr1, mem1, ld1, ctl1;
    logic       u2_rs1, u2_rs2, wr2, mem2, ld2, ctl2;
    logic       unused_ctl2;

    inst_dec_lite u_dec1 (
        .inst(out1_inst), .rd(rd1), .rs1(rs1_1), .rs2(rs2_1),
        .use_rs1(u1_rs1), .use_rs2(u1_rs2), .wr_rd(wr1),
        .is_mem(mem1), .is_ld(ld1), .is_ctl(ctl1)
    );

    inst_dec_lite u_dec2 (
        .inst(out2_inst), .rd(rd2), .rs1(rs1_2), .rs2(rs2_2),
        .use_rs1(u2_rs1), .use_rs2(u2_rs2), .wr_rd(wr2),
        .is_mem(mem2), .is_ld(ld2), .is_ctl(ctl2)
    );

    assign unused_ctl2 = ctl2;

    state_e           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             ld_v_q, ld_v_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] dual_cnt_q, dual_cnt_d;

    logic lu_hz1, lu_hz2, raw, waw, can_go, launch1, launch2;
    logic ld_from1, ld_from2;

    always_comb begin
        lu_hz1 = ld_v_q && ((u1_rs1 && (rs1_1 == ld_rd_q)) || (u1_rs2 && (rs2_1 == ld_rd_q)));
        lu_hz2 = ld_v_q && ((u2_rs1 && (rs1_2 == ld_rd_q)) || (u2_rs2 && (rs2_2 == ld_rd_q)));
        raw    = wr1 && ((u2_rs1 && (rs1_2 == rd1)) || (u2_rs2 && (rs2_2 == rd1)));
        waw    = wr1 && wr2 && (rd1 == rd2);
        can_go = (state_q == ST_RUN) && !branch_flag && sendout_flag1 && ex_ready;
        // rst gates the flags so the buffer never sees a launch during reset
        launch1 = rst && can_go && !lu_hz1;
        launch2 = launch1 && sendout_flag2 && !lu_hz2 && !raw && !waw
                  && !(mem1 && mem2) && !ctl1;
        ld_from1 = launch1 && ld1 && wr1;
        ld_from2 = launch2 && ld2 && wr2;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (branch_flag) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                // a fresh misprediction inside the window restarts it
                if (branch_flag) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q != 4'd0) begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        ld_v_d  = ld_v_q;
        ld_rd_d = ld_rd_q;
        if (branch_flag) begin
            ld_v_d = 1'b0;
        end else if (ex_ready) begin
            ld_v_d = ld_from1 || ld_from2;
            if (ld_from1) begin
                ld_rd_d = rd1;
            end else if (ld_from2) begin
                ld_rd_d = rd2;
            end
        end

        stall_cnt_d = (can_go && !launch1) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        dual_cnt_d  = launch2 ? sat_inc(dual_cnt_q) : dual_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
            ld_v_q      <= 1'b0;
            ld_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
            dual_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ld_v_q      <= ld_v_d;
            ld_rd_q     <= ld_rd_d;
            stall_cnt_q <= stall_cnt_d;
            dual_cnt_q  <= dual_cnt_d;
        end
    end

    assign launch_flag1 = launch1;
    assign launch_flag2 = launch2;
    assign stall_cnt    = stall_cnt_q;
    assign dual_cnt     = dual_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed vector bench for issue_ctrl with FLUSH_CYCLES=3 and narrow
// counters so saturation is reachable.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sv1, sv2, exr, br;
    logic [31:0]   i1, i2;
    logic          l1, l2;
    logic [CW-1:0] stall_cnt, dual_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    issue_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .sendout_flag1(sv1), .sendout_flag2(sv2),
        .out1_inst(i1), .out2_inst(i2),
        .ex_ready(exr), .branch_flag(br),
        .launch_flag1(l1), .launch_flag2(l2),
        .stall_cnt(stall_cnt), .dual_cnt(dual_cnt)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
        return {imm, rs, 3'b000, rd, OPC_OP_IMM};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'b0, b, a, 3'b000, rd, OPC_OP};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] base);
        return {12'd0, base, 3'b010, rd, OPC_LOAD};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] src, input logic [4:0] base);
        return {7'd0, src, base, 3'b010, 5'd0, OPC_STORE};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] a, input logic [4:0] b);
        return {7'd0, b, a, 3'b000, 5'd0, OPC_BRANCH};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'd0, rd, OPC_JAL};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e1, input logic e2);
        chk({tag, "_l1"}, {31'd0, l1}, {31'd0, e1});
        chk({tag, "_l2"}, {31'd0, l2}, {31'd0, e2});
    endtask

    task automatic apply(input logic a_sv1, input logic a_sv2, input logic [31:0] a_i1,
                         input logic [31:0] a_i2, input logic a_exr, input logic a_br);
        @(negedge clk);
        sv1 = a_sv1; sv2 = a_sv2; i1 = a_i1; i2 = a_i2; exr = a_exr; br = a_br;
        #1;
    endtask

    typedef struct {
        logic        sv1, sv2;
        logic [31:0] i1, i2;
        logic        exr, br;
        logic        e1, e2;
        logic [3:0]  stall, dual;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 1, addi(1, 2, 1),   addi(3, 4, 1),  1, 0, 1, 1, 0, 0};
        tbl[1]  = '{1, 1, addi(5, 0, 1),   add(6, 5, 5),   1, 0, 1, 0, 0, 1};
        tbl[2]  = '{1, 0, add(6, 5, 5),    NOP,            1, 0, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, lw(7, 1),        add(8, 7, 1),   1, 0, 1, 0, 0, 1};
        tbl[4]  = '{1, 0, add(8, 7, 1),    NOP,            1, 0, 0, 0, 0, 1};
        tbl[5]  = '{1, 0, add(8, 7, 1),    NOP,            1, 0, 1, 0, 1, 1};
        tbl[6]  = '{1, 1, lw(1, 2),        sw(2, 3),       1, 0, 1, 0, 1, 1};
        tbl[7]  = '{1, 1, beq(4, 5),       addi(3, 3, 1),  1, 0, 1, 0, 1, 1};
        tbl[8]  = '{1, 1, addi(0, 1, 5),   add(9, 0, 0),   1, 0, 1, 1, 1, 1};
        tbl[9]  = '{1, 1, addi(11, 1, 1),  lw(12, 2),      1, 0, 1, 1, 1, 2};
        tbl[10] = '{1, 1, addi(13, 1, 1),  add(14, 12, 0), 1, 0, 1, 0, 1, 3};
        tbl[11] = '{0, 1, addi(1, 2, 3),   addi(3, 4, 5),  1, 0, 0, 0, 1, 3};
        tbl[12] = '{1, 0, addi(1, 2, 3),   NOP,            0, 0, 0, 0, 1, 3};
        tbl[13] = '{1, 1, addi(15, 1, 1),  addi(15, 2, 1), 1, 0, 1, 0, 1, 3};
        tbl[14] = '{1, 1, jal(1),          addi(2, 3, 1),  1, 0, 1, 0, 1, 3};
        tbl[15] = '{1, 1, addi(16, 0, 1),  sw(16, 2),      1, 0, 1, 0, 1, 3};

        // reset with a valid head: no launch, counters clear
        rst = 1'b0; sv1 = 1; sv2 = 1; i1 = addi(1, 2, 1); i2 = addi(3, 4, 1); exr = 1; br = 0;
        #2;
        chk_flags("reset", 0, 0);
        chk("reset_stall", {28'd0, stall_cnt}, 0);
        chk("reset_dual", {28'd0, dual_cnt}, 0);
        repeat (2) @(negedge clk);
        sv1 = 0; sv2 = 0;
        rst = 1'b1;

        for (int k = 0; k < 16; k++) begin
            apply(tbl[k].sv1, tbl[k].sv2, tbl[k].i1, tbl[k].i2, tbl[k].exr, tbl[k].br);
            chk_flags($sformatf("vec%0d", k), tbl[k].e1, tbl[k].e2);
            chk($sformatf("vec%0d_stall", k), {28'd0, stall_cnt}, {28'd0, tbl[k].stall});
            chk($sformatf("vec%0d_dual", k), {28'd0, dual_cnt}, {28'd0, tbl[k].dual});
        end

        // load-use held across ex_ready=0, then one stall, then launch
        apply(1, 0, lw(7, 1), NOP, 1, 0);
        chk_flags("lu_load", 1, 0);
        for (int k = 0; k < 5; k++) begin
            apply(1, 0, add(8, 7, 1), NOP, 0, 0);
            chk_flags($sformatf("hold%0d", k), 0, 0);
            chk($sformatf("hold%0d_stall", k), {28'd0, stall_cnt}, 1);
        end
        apply(1, 0, add(8, 7, 1), NOP, 1, 0);
        chk_flags("lu_stall", 0, 0);
        chk("lu_stall_cnt", {28'd0, stall_cnt}, 1);
        apply(1, 0, add(8, 7, 1), NOP, 1, 0);
        chk_flags("lu_go", 1, 0);
        chk("lu_go_stall", {28'd0, stall_cnt}, 2);

        // flush window of 3 after the branch cycle; branch also drops the load
        apply(1, 0, lw(7, 1), NOP, 1, 0);
        chk_flags("fl_load", 1, 0);
        apply(1, 0, add(8, 7, 1), NOP, 0, 1);
        chk_flags("fl_br", 0, 0);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, add(8, 7, 1), NOP, 0, 0);
            chk_flags($sformatf("fl_win%0d", k), 0, 0);
        end
        apply(1, 0, add(8, 7, 1), NOP, 1, 0);
        chk_flags("fl_resume", 1, 0);
        chk("fl_resume_stall", {28'd0, stall_cnt}, 2);

        // second branch inside the window restarts the count
        apply(1, 0, addi(1, 2, 1), NOP, 1, 1);
        chk_flags("rb_c0", 0, 0);
        apply(1, 0, addi(1, 2, 1), NOP, 1, 0);
        chk_flags("rb_c1", 0, 0);
        apply(1, 0, addi(1, 2, 1), NOP, 1, 1);
        chk_flags("rb_c2", 0, 0);
        for (int k = 3; k < 6; k++) begin
            apply(1, 0, addi(1, 2, 1), NOP, 1, 0);
            chk_flags($sformatf("rb_c%0d", k), 0, 0);
        end
        apply(1, 0, addi(1, 2, 1), NOP, 1, 0);
        chk_flags("rb_c6", 1, 0);
        chk("rb_stall", {28'd0, stall_cnt}, 2);

        // dual counter saturates at all-ones
        for (int k = 0; k < 14; k++) begin
            apply(1, 1, addi(1, 2, 1), addi(3, 4, 1), 1, 0);
            chk_flags($sformatf("sat%0d", k), 1, 1);
        end
        apply(0, 0, NOP, NOP, 1, 0);
        chk_flags("sat_idle", 0, 0);
        chk("sat_dual", {28'd0, dual_cnt}, 15);

        // async reset in the middle of a flush window
        apply(1, 0, addi(1, 2, 1), NOP, 1, 1);
        chk_flags("rf_br", 0, 0);
        @(negedge clk);
        br = 0; rst = 1'b0;
        #1;
        chk_flags("rf_in_reset", 0, 0);
        chk("rf_stall", {28'd0, stall_cnt}, 0);
        chk("rf_dual", {28'd0, dual_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_flags("rf_run", 1, 0);

        // reset drops a pending load
        apply(1, 0, lw(7, 1), NOP, 1, 0);
        chk_flags("rl_load", 1, 0);
        @(negedge clk);
        i1 = add(8, 7, 1); rst = 1'b0;
        #1;
        chk_flags("rl_in_reset", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_flags("rl_go", 1, 0);
        chk("rl_stall", {28'd0, stall_cnt}, 0);
        chk("rl_dual", {28'd0, dual_cnt}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
